fetch_unit: RTL and testbench

- Instruction-fetch front end that produces the instruction word whose Opcode field feeds the main control decoder.
- Owns the PC and issues single-outstanding requests to instruction memory with a req/ready address handshake and an rvalid data return.
- Presents a registered IF/ID instruction plus decoded fields, with stall, flush and redirect support.

---
 rtl/fetch_unit.sv | 169 ++++++++++++++++
 tb/tb_fetch_unit.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one outstanding imem request
// at a time and presents a registered IF/ID instruction with decoded fields.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_REQ  | imem_req high at PC; waiting for imem_ready
// S_WAIT | request accepted; waiting for imem_rvalid
// S_FULL | response parked in skid buffer until IF/ID frees up
// S_DROP | response of a flushed request still owed; discard it on arrival
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        Stall,
   input  logic        Redirect,
   input  logic [31:0] RedirectPC,
   output logic        InstrValid,
   output logic [31:0] Instr,
   output logic [5:0]  Opcode,
   output logic [4:0]  Rs,
   output logic [4:0]  Rt,
   output logic [4:0]  Rd,
   output logic [5:0]  Funct,
   output logic [15:0] Imm16,
   output logic [31:0] PCPlus4
);

   localparam logic [1:0] S_REQ  = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_FULL = 2'd2;
   localparam logic [1:0] S_DROP = 2'd3;

   logic [1:0]  state, stateNext;
   logic [31:0] pc, pcNext;
   logic [31:0] tagPc, tagPcNext;
   logic [31:0] instrQ, instrNext;
   logic        instrValidQ, validNext;
   logic [31:0] pcPlus4Q, pcPlus4Next;
   logic [31:0] skidInstr, skidInstrNext;
   logic [31:0] skidPcPlus4, skidPcPlus4Next;

   logic        ifIdFree;
   logic        newWord;
   logic [31:0] newInstr;
   logic [31:0] newPcPlus4;
   logic [31:0] redirectAligned;
   logic [1:0]  unusedRedirectBits;

   assign redirectAligned    = {RedirectPC[31:2], 2'b00};
   assign unusedRedirectBits = RedirectPC[1:0];
   assign ifIdFree           = !instrValidQ || !Stall;

   always_comb begin
      stateNext       = state;
      pcNext          = pc;
      tagPcNext       = tagPc;
      instrNext       = instrQ;
      validNext       = instrValidQ;
      pcPlus4Next     = pcPlus4Q;
      skidInstrNext   = skidInstr;
      skidPcPlus4Next = skidPcPlus4;
      newWord         = 1'b0;
      newInstr        = NOP_INSTR;
      newPcPlus4      = pcPlus4Q;

      if (Redirect) begin
         pcNext        = redirectAligned;
         validNext     = 1'b0;
         instrNext     = NOP_INSTR;
         skidInstrNext = NOP_INSTR;
         // A request already accepted (or accepted this cycle) still owes a response.
         case (state)
            S_REQ:   stateNext = imem_ready  ? S_DROP : S_REQ;
            S_WAIT:  stateNext = imem_rvalid ? S_REQ  : S_DROP;
            S_DROP:  stateNext = imem_rvalid ? S_REQ  : S_DROP;
            default: stateNext = S_REQ;
         endcase
      end else begin
         case (state)
            S_REQ: begin
               if (imem_ready) begin
                  tagPcNext = pc;
                  pcNext    = pc + 32'd4;
                  stateNext = S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  if (ifIdFree) begin
                     newWord    = 1'b1;
                     newInstr   = imem_rdata;
                     newPcPlus4 = tagPc + 32'd4;
                     stateNext  = S_REQ;
                  end else begin
                     skidInstrNext   = imem_rdata;
                     skidPcPlus4Next = tagPc + 32'd4;
                     stateNext       = S_FULL;
                  end
               end
            end
            S_FULL: begin
               if (!Stall) begin
                  newWord    = 1'b1;
                  newInstr   = skidInstr;
                  newPcPlus4 = skidPcPlus4;
                  stateNext  = S_REQ;
               end
            end
            S_DROP: begin
               if (imem_rvalid) begin
                  stateNext = S_REQ;
               end
            end
            default: stateNext = S_REQ;
         endcase

         if (newWord) begin
            instrNext   = newInstr;
            pcPlus4Next = newPcPlus4;
            validNext   = 1'b1;
         end else if (!Stall) begin
            instrNext = NOP_INSTR;
            validNext = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_REQ;
         pc          <= RESET_PC;
         tagPc       <= RESET_PC;
         instrQ      <= NOP_INSTR;
         instrValidQ <= 1'b0;
         pcPlus4Q    <= RESET_PC + 32'd4;
         skidInstr   <= NOP_INSTR;
         skidPcPlus4 <= RESET_PC + 32'd4;
      end else begin
         state       <= stateNext;
         pc          <= pcNext;
         tagPc       <= tagPcNext;
         instrQ      <= instrNext;
         instrValidQ <= validNext;
         pcPlus4Q    <= pcPlus4Next;
         skidInstr   <= skidInstrNext;
         skidPcPlus4 <= skidPcPlus4Next;
      end
   end

   assign imem_req   = (state == S_REQ) && !reset;
   assign imem_addr  = pc;
   assign InstrValid = instrValidQ;
   assign Instr      = instrQ;
   assign Opcode     = instrQ[31:26];
   assign Rs         = instrQ[25:21];
   assign Rt         = instrQ[20:16];
   assign Rd         = instrQ[15:11];
   assign Funct      = instrQ[5:0];
   assign Imm16      = instrQ[15:0];
   assign PCPlus4    = pcPlus4Q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run checked against
// an address-stream model (fetch order, delivery order, one outstanding request).
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        Stall;
   logic        Redirect;
   logic [31:0] RedirectPC;
   logic        InstrValid;
   logic [31:0] Instr;
   logic [5:0]  Opcode;
   logic [4:0]  Rs;
   logic [4:0]  Rt;
   logic [4:0]  Rd;
   logic [5:0]  Funct;
   logic [15:0] Imm16;
   logic [31:0] PCPlus4;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .Stall(Stall), .Redirect(Redirect), .RedirectPC(RedirectPC),
      .InstrValid(InstrValid), .Instr(Instr), .Opcode(Opcode),
      .Rs(Rs), .Rt(Rt), .Rd(Rd), .Funct(Funct), .Imm16(Imm16), .PCPlus4(PCPlus4)
   );

   int vectors = 0;
   int miscompares = 0;

   // memory responder state
   int          readyMode;   // 0 always ready, 1 never ready, 2 random
   int          latMin, latMax;
   logic [31:0] dataKey;
   logic        overrideOn;
   logic [31:0] overrideData;
   logic        pending;
   int          pendCnt;
   logic [31:0] pendAddr;
   logic        lastReq, lastHs, lastRvalid;
   logic [31:0] lastAddr;
   logic [31:0] e;

   // One clock: drive memory inputs at negedge, sample request side, advance.
   task tick();
      case (readyMode)
         0:       imem_ready = 1'b1;
         1:       imem_ready = 1'b0;
         default: imem_ready = ($urandom_range(99) < 70);
      endcase
      if (pending && pendCnt == 0) begin
         imem_rvalid = 1'b1;
         imem_rdata  = overrideOn ? overrideData : (pendAddr ^ dataKey);
         overrideOn  = 1'b0;
         pending     = 1'b0;
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
      end
      #1;
      lastReq    = imem_req;
      lastAddr   = imem_addr;
      lastHs     = imem_req && imem_ready;
      lastRvalid = imem_rvalid;
      @(posedge clk);
      if (reset) begin
         pending = 1'b0;
      end else begin
         if (pending) pendCnt--;
         if (lastHs) begin
            pending  = 1'b1;
            pendAddr = lastAddr;
            pendCnt  = int'($urandom_range(latMax, latMin)) - 1;
         end
      end
      @(negedge clk);
   endtask

   task test_reset();
      reset = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirectPC = '0;
      readyMode = 0; latMin = 1; latMax = 1; dataKey = '0;
      overrideOn = 1'b0; pending = 1'b0;
      repeat (2) tick();
      vectors++;
      if (lastReq !== 1'b0) begin
         miscompares++; $display("FAIL reset_req got %b want 0", lastReq);
      end
      vectors++;
      if ({InstrValid, Instr, PCPlus4} !== {1'b0, 32'h0, 32'h4}) begin
         miscompares++;
         $display("FAIL reset_ifid got %h want %h", {InstrValid, Instr, PCPlus4}, {1'b0, 32'h0, 32'h4});
      end
      vectors++;
      if ({Opcode, Rs, Rt, Rd, Funct, Imm16} !== 43'h0) begin
         miscompares++;
         $display("FAIL reset_fields got %h want 0", {Opcode, Rs, Rt, Rd, Funct, Imm16});
      end
      reset = 1'b0;
   endtask

   task test_sequential();
      for (int i = 0; i < 4; i++) begin
         e = 32'(4 * i);
         tick();
         vectors++;
         if ({lastHs, lastAddr, InstrValid} !== {1'b1, e, 1'b0}) begin
            miscompares++;
            $display("FAIL seq_fetch got %h want %h", {lastHs, lastAddr, InstrValid}, {1'b1, e, 1'b0});
         end
         tick();
         vectors++;
         if ({lastReq, InstrValid, Instr, PCPlus4} !== {1'b0, 1'b1, e, e + 32'd4}) begin
            miscompares++;
            $display("FAIL seq_ifid got %h want %h", {lastReq, InstrValid, Instr, PCPlus4}, {1'b0, 1'b1, e, e + 32'd4});
         end
      end
   endtask

   task test_ready_low();
      readyMode = 1;
      for (int k = 0; k < 3; k++) begin
         tick();
         vectors++;
         if ({lastReq, lastHs, lastAddr} !== {1'b1, 1'b0, 32'h10}) begin
            miscompares++;
            $display("FAIL hold_addr got %h want %h", {lastReq, lastHs, lastAddr}, {1'b1, 1'b0, 32'h10});
         end
      end
      readyMode = 0;
      tick();
      vectors++;
      if ({lastHs, lastAddr} !== {1'b1, 32'h10}) begin
         miscompares++; $display("FAIL hold_accept got %h want %h", {lastHs, lastAddr}, {1'b1, 32'h10});
      end
      tick();
      vectors++;
      if ({InstrValid, Instr, PCPlus4} !== {1'b1, 32'h10, 32'h14}) begin
         miscompares++;
         $display("FAIL hold_ifid got %h want %h", {InstrValid, Instr, PCPlus4}, {1'b1, 32'h10, 32'h14});
      end
   endtask

   task test_stall();
      Stall = 1'b1; overrideOn = 1'b1; overrideData = 32'h8C22_0004;
      tick();
      vectors++;
      if ({lastHs, lastAddr, InstrValid, Instr} !== {1'b1, 32'h14, 1'b1, 32'h10}) begin
         miscompares++;
         $display("FAIL stall_fetch got %h want %h", {lastHs, lastAddr, InstrValid, Instr}, {1'b1, 32'h14, 1'b1, 32'h10});
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         vectors++;
         if ({lastReq, InstrValid, Instr, PCPlus4} !== {1'b0, 1'b1, 32'h10, 32'h14}) begin
            miscompares++;
            $display("FAIL stall_hold got %h want %h", {lastReq, InstrValid, Instr, PCPlus4}, {1'b0, 1'b1, 32'h10, 32'h14});
         end
      end
      Stall = 1'b0;
      tick();
      vectors++;
      if ({lastReq, InstrValid, Instr, PCPlus4} !== {1'b0, 1'b1, 32'h8C22_0004, 32'h18}) begin
         miscompares++;
         $display("FAIL stall_release got %h want %h", {lastReq, InstrValid, Instr, PCPlus4}, {1'b0, 1'b1, 32'h8C22_0004, 32'h18});
      end
      vectors++;
      if ({Opcode, Rs, Rt, Imm16} !== {6'b100011, 5'd1, 5'd2, 16'h0004}) begin
         miscompares++;
         $display("FAIL stall_fields got %h want %h", {Opcode, Rs, Rt, Imm16}, {6'b100011, 5'd1, 5'd2, 16'h0004});
      end
      tick();
      vectors++;
      if ({lastHs, lastAddr, InstrValid} !== {1'b1, 32'h18, 1'b0}) begin
         miscompares++;
         $display("FAIL stall_next got %h want %h", {lastHs, lastAddr, InstrValid}, {1'b1, 32'h18, 1'b0});
      end
      tick();
      vectors++;
      if ({InstrValid, Instr, PCPlus4} !== {1'b1, 32'h18, 32'h1C}) begin
         miscompares++;
         $display("FAIL stall_after got %h want %h", {InstrValid, Instr, PCPlus4}, {1'b1, 32'h18, 32'h1C});
      end
   endtask

   task test_redirect_wait();
      latMin = 3; latMax = 3; overrideOn = 1'b1; overrideData = 32'hDEAD_BEEF;
      tick();
      vectors++;
      if ({lastHs, lastAddr} !== {1'b1, 32'h1C}) begin
         miscompares++; $display("FAIL rw_fetch got %h want %h", {lastHs, lastAddr}, {1'b1, 32'h1C});
      end
      Redirect = 1'b1; RedirectPC = 32'h100;
      tick();
      vectors++;
      if ({InstrValid, Instr} !== {1'b0, 32'h0}) begin
         miscompares++; $display("FAIL rw_flush got %h want %h", {InstrValid, Instr}, {1'b0, 32'h0});
      end
      Redirect = 1'b0; latMin = 1; latMax = 1;
      for (int k = 0; k < 2; k++) begin
         tick();
         vectors++;
         if ({lastReq, InstrValid, Instr} !== {1'b0, 1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL rw_drop got %h want %h", {lastReq, InstrValid, Instr}, {1'b0, 1'b0, 32'h0});
         end
      end
      tick();
      vectors++;
      if ({lastHs, lastAddr} !== {1'b1, 32'h100}) begin
         miscompares++; $display("FAIL rw_refetch got %h want %h", {lastHs, lastAddr}, {1'b1, 32'h100});
      end
      tick();
      vectors++;
      if ({InstrValid, Instr, PCPlus4} !== {1'b1, 32'h100, 32'h104}) begin
         miscompares++;
         $display("FAIL rw_ifid got %h want %h", {InstrValid, Instr, PCPlus4}, {1'b1, 32'h100, 32'h104});
      end
   endtask

   task test_redirect_stall();
      Stall = 1'b1;
      tick();
      vectors++;
      if ({lastHs, lastAddr} !== {1'b1, 32'h104}) begin
         miscompares++; $display("FAIL rs_fetch got %h want %h", {lastHs, lastAddr}, {1'b1, 32'h104});
      end
      tick();
      vectors++;
      if ({InstrValid, Instr} !== {1'b1, 32'h100}) begin
         miscompares++; $display("FAIL rs_hold got %h want %h", {InstrValid, Instr}, {1'b1, 32'h100});
      end
      Redirect = 1'b1; RedirectPC = 32'h200;
      tick();
      vectors++;
      if ({lastReq, InstrValid, Instr} !== {1'b0, 1'b0, 32'h0}) begin
         miscompares++;
         $display("FAIL rs_flush got %h want %h", {lastReq, InstrValid, Instr}, {1'b0, 1'b0, 32'h0});
      end
      Redirect = 1'b0; Stall = 1'b0;
      tick();
      vectors++;
      if ({lastHs, lastAddr} !== {1'b1, 32'h200}) begin
         miscompares++; $display("FAIL rs_refetch got %h want %h", {lastHs, lastAddr}, {1'b1, 32'h200});
      end
      tick();
      vectors++;
      if ({InstrValid, Instr, PCPlus4} !== {1'b1, 32'h200, 32'h204}) begin
         miscompares++;
         $display("FAIL rs_ifid got %h want %h", {InstrValid, Instr, PCPlus4}, {1'b1, 32'h200, 32'h204});
      end
   endtask

   task test_wrap();
      Redirect = 1'b1; RedirectPC = 32'hFFFF_FFFC;
      tick();
      vectors++;
      if ({lastHs, lastAddr, InstrValid} !== {1'b1, 32'h204, 1'b0}) begin
         miscompares++;
         $display("FAIL wrap_redirect got %h want %h", {lastHs, lastAddr, InstrValid}, {1'b1, 32'h204, 1'b0});
      end
      Redirect = 1'b0;
      tick();
      vectors++;
      if ({lastReq, InstrValid, Instr} !== {1'b0, 1'b0, 32'h0}) begin
         miscompares++;
         $display("FAIL wrap_drop got %h want %h", {lastReq, InstrValid, Instr}, {1'b0, 1'b0, 32'h0});
      end
      tick();
      vectors++;
      if ({lastHs, lastAddr} !== {1'b1, 32'hFFFF_FFFC}) begin
         miscompares++; $display("FAIL wrap_fetch0 got %h want %h", {lastHs, lastAddr}, {1'b1, 32'hFFFF_FFFC});
      end
      tick();
      vectors++;
      if ({InstrValid, Instr, PCPlus4} !== {1'b1, 32'hFFFF_FFFC, 32'h0}) begin
         miscompares++;
         $display("FAIL wrap_ifid0 got %h want %h", {InstrValid, Instr, PCPlus4}, {1'b1, 32'hFFFF_FFFC, 32'h0});
      end
      tick();
      vectors++;
      if ({lastHs, lastAddr} !== {1'b1, 32'h0}) begin
         miscompares++; $display("FAIL wrap_fetch1 got %h want %h", {lastHs, lastAddr}, {1'b1, 32'h0});
      end
      tick();
      vectors++;
      if ({InstrValid, Instr, PCPlus4} !== {1'b1, 32'h0, 32'h4}) begin
         miscompares++;
         $display("FAIL wrap_ifid1 got %h want %h", {InstrValid, Instr, PCPlus4}, {1'b1, 32'h0, 32'h4});
      end
   endtask

   task test_random();
      logic [31:0] expFetch, expCons, expWord;
      logic        outstanding;
      int          consumed;
      reset = 1'b1; Stall = 1'b0; Redirect = 1'b0; readyMode = 0;
      repeat (2) tick();
      reset = 1'b0; readyMode = 2; latMin = 1; latMax = 4;
      dataKey = $urandom | 32'h1;
      expFetch = '0; expCons = '0; outstanding = 1'b0; consumed = 0;
      for (int c = 0; c < 4000; c++) begin
         reset      = ($urandom_range(199) == 0);
         Stall      = ($urandom_range(99) < 30);
         Redirect   = !reset && ($urandom_range(99) < 4);
         RedirectPC = ($urandom_range(1) != 0) ? $urandom : (32'hFFFF_FFF0 | ($urandom & 32'hF));
         if (!reset && InstrValid && !Stall && !Redirect) begin
            expWord = expCons ^ dataKey;
            vectors++;
            if ({Instr, PCPlus4, Opcode} !== {expWord, expCons + 32'd4, expWord[31:26]}) begin
               miscompares++;
               $display("FAIL rnd_deliver got %h want %h", {Instr, PCPlus4, Opcode}, {expWord, expCons + 32'd4, expWord[31:26]});
            end
            expCons  = expCons + 32'd4;
            consumed++;
         end else if (!InstrValid) begin
            vectors++;
            if (Instr !== 32'h0) begin
               miscompares++; $display("FAIL rnd_bubble got %h want 0", Instr);
            end
         end
         tick();
         if (reset) begin
            vectors++;
            if (lastReq !== 1'b0) begin
               miscompares++; $display("FAIL rnd_reset_req got %b want 0", lastReq);
            end
            expFetch = '0; expCons = '0; outstanding = 1'b0;
         end else begin
            if (lastReq) begin
               vectors++;
               if ({outstanding, lastAddr} !== {1'b0, expFetch}) begin
                  miscompares++;
                  $display("FAIL rnd_fetch got %h want %h", {outstanding, lastAddr}, {1'b0, expFetch});
               end
            end
            if (lastRvalid) outstanding = 1'b0;
            if (lastHs) outstanding = 1'b1;
            if (Redirect) begin
               expFetch = RedirectPC & ~32'h3;
               expCons  = expFetch;
            end else if (lastHs) begin
               expFetch = expFetch + 32'd4;
            end
         end
      end
      reset = 1'b0; Stall = 1'b0; Redirect = 1'b0;
      vectors++;
      if (consumed < 200) begin
         miscompares++; $display("FAIL rnd_progress got %0d want >=200", consumed);
      end
   endtask

   initial begin
      reset = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirectPC = '0;
      imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      readyMode = 0; latMin = 1; latMax = 1; dataKey = '0;
      overrideOn = 1'b0; overrideData = '0; pending = 1'b0; pendCnt = 0; pendAddr = '0;
      @(negedge clk);
      test_reset();
      test_sequential();
      test_ready_low();
      test_stall();
      test_redirect_wait();
      test_redirect_stall();
      test_wrap();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
